// File: rtl/hvac_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hvac_pkg : shared encodings and default thresholds for the HVAC blocks.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package hvac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_DEAD  = 2'd2
    } state_t;

    typedef enum logic {
        MODE_HEAT = 1'b0,
        MODE_COOL = 1'b1
    } mode_t;

    // Also used by the single-room AC controller.
    localparam int HEAT_TH_DEF = 18;
    localparam int COOL_TH_DEF = 22;

endpackage
`default_nettype wire

// File: rtl/hvac_rr_picker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hvac_rr_picker : combinational round-robin search starting at ptr+1.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module hvac_rr_picker #(
    parameter int NZONES = 4,
    parameter int PW     = $clog2(NZONES)
) (
    input  logic [NZONES-1:0] i_demand,
    input  logic [PW-1:0]     i_ptr,
    output logic [PW-1:0]     o_idx,
    output logic              o_valid
);

    logic [PW-1:0] w_cand;

    // Scan from the farthest offset down so the nearest requester after ptr wins.
    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = '0;
        for (int k = NZONES; k >= 1; k--) begin
            w_cand = PW'((int'(i_ptr) + k) % NZONES);
            if (i_demand[w_cand]) begin
                o_idx   = w_cand;
                o_valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hvac_zone_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hvac_zone_scheduler : round-robin sharing of one heat/cool plant between |
// | NZONES rooms with minimum run time. Optional dead time: HVAC_DEADTIME_EN |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module hvac_zone_scheduler
    import hvac_pkg::*;
#(
    parameter int NZONES  = 4,
    parameter int TW      = 5,
    parameter int HEAT_TH = HEAT_TH_DEF,
    parameter int COOL_TH = COOL_TH_DEF,
    parameter int MIN_RUN = 8,
    parameter int DEAD    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [NZONES*TW-1:0] temperature,
    output logic                 heating,
    output logic                 cooling,
    output logic [NZONES-1:0]    zone_sel
);

    localparam int PW = $clog2(NZONES);
    localparam int RW = (MIN_RUN > 1) ? $clog2(MIN_RUN) : 1;
    localparam logic [RW-1:0] C_RUN_LAST = RW'(MIN_RUN - 1);

    logic [NZONES-1:0] w_heat_dem;
    logic [NZONES-1:0] w_cool_dem;
    logic [NZONES-1:0] w_dem;

    for (genvar gi = 0; gi < NZONES; gi++) begin : g_demand
        logic [TW-1:0] w_t;
        assign w_t            = temperature[gi*TW +: TW];
        assign w_heat_dem[gi] = (w_t <= TW'(HEAT_TH));
        assign w_cool_dem[gi] = (w_t >= TW'(COOL_TH));
    end
    assign w_dem = w_heat_dem | w_cool_dem;

    state_t            r_state, w_state_nx;
    mode_t             r_mode,  w_mode_nx;
    logic [PW-1:0]     r_ptr,   w_ptr_nx;
    logic [RW-1:0]     r_run,   w_run_nx;
    logic              r_heating, w_heating_nx;
    logic              r_cooling, w_cooling_nx;
    logic [NZONES-1:0] r_sel,     w_sel_nx;

`ifdef HVAC_DEADTIME_EN
    localparam int DW = (DEAD > 1) ? $clog2(DEAD) : 1;
    localparam logic [DW-1:0] C_DEAD_LAST = DW'(DEAD - 1);
    logic [DW-1:0] r_dead, w_dead_nx;
`else
    // DEAD only matters when the dead-time state is built.
    logic w_unused_dead;
    assign w_unused_dead = (DEAD > 0);
`endif

    logic [PW-1:0]     w_pick_idx;
    logic              w_pick_valid;

    hvac_rr_picker #(
        .NZONES (NZONES),
        .PW     (PW)
    ) u_picker (
        .i_demand (w_dem),
        .i_ptr    (r_ptr),
        .o_idx    (w_pick_idx),
        .o_valid  (w_pick_valid)
    );

    // In SERVE, r_ptr is the granted zone.
    logic [NZONES-1:0] w_gnt_oh;
    logic              w_keep;
    logic              w_other;
    logic              w_run_done;
    logic              w_release;

    assign w_gnt_oh   = NZONES'(1) << r_ptr;
    assign w_keep     = (r_mode == MODE_HEAT) ? w_heat_dem[r_ptr] : w_cool_dem[r_ptr];
    assign w_other    = |(w_dem & ~w_gnt_oh);
    assign w_run_done = (r_run >= C_RUN_LAST);
    assign w_release  = w_run_done & (~w_keep | ~enable | w_other);

    always_comb begin
        w_state_nx   = r_state;
        w_mode_nx    = r_mode;
        w_ptr_nx     = r_ptr;
        w_run_nx     = r_run;
        w_heating_nx = 1'b0;
        w_cooling_nx = 1'b0;
        w_sel_nx     = '0;
`ifdef HVAC_DEADTIME_EN
        w_dead_nx    = r_dead;
`endif
        case (r_state)
            ST_IDLE: begin
                if (enable && w_pick_valid) begin
                    w_state_nx   = ST_SERVE;
                    w_ptr_nx     = w_pick_idx;
                    w_mode_nx    = w_heat_dem[w_pick_idx] ? MODE_HEAT : MODE_COOL;
                    w_run_nx     = '0;
                    w_heating_nx = w_heat_dem[w_pick_idx];
                    w_cooling_nx = ~w_heat_dem[w_pick_idx];
                    w_sel_nx     = NZONES'(1) << w_pick_idx;
                end
            end
            ST_SERVE: begin
                if (w_release) begin
`ifdef HVAC_DEADTIME_EN
                    w_state_nx = ST_DEAD;
                    w_dead_nx  = '0;
`else
                    w_state_nx = ST_IDLE;
`endif
                end else begin
                    w_heating_nx = (r_mode == MODE_HEAT);
                    w_cooling_nx = (r_mode == MODE_COOL);
                    w_sel_nx     = w_gnt_oh;
                    if (!w_run_done) begin
                        w_run_nx = r_run + 1'b1;
                    end
                end
            end
`ifdef HVAC_DEADTIME_EN
            ST_DEAD: begin
                if (r_dead == C_DEAD_LAST) begin
                    w_state_nx = ST_IDLE;
                end else begin
                    w_dead_nx = r_dead + 1'b1;
                end
            end
`endif
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_mode    <= MODE_HEAT;
            r_ptr     <= PW'(NZONES - 1);
            r_run     <= '0;
            r_heating <= 1'b0;
            r_cooling <= 1'b0;
            r_sel     <= '0;
`ifdef HVAC_DEADTIME_EN
            r_dead    <= '0;
`endif
        end else begin
            r_state   <= w_state_nx;
            r_mode    <= w_mode_nx;
            r_ptr     <= w_ptr_nx;
            r_run     <= w_run_nx;
            r_heating <= w_heating_nx;
            r_cooling <= w_cooling_nx;
            r_sel     <= w_sel_nx;
`ifdef HVAC_DEADTIME_EN
            r_dead    <= w_dead_nx;
`endif
        end
    end

    assign heating  = r_heating;
    assign cooling  = r_cooling;
    assign zone_sel = r_sel;

endmodule
`default_nettype wire
